// File: rtl/digit_scan_ctrl_if.sv
// rtl/digit_scan_ctrl_if.sv - bus bundle between score logic, digit scanner and display pins
//
// Purpose : groups the scanner's control/data inputs and its display outputs.
// Signals : en, load, digits_in[15:0]       - driven by the score logic (master)
//           code[3:0], an[3:0], nibble[3:0],
//           frame_tick, pending              - driven by the scanner (slave)
interface digit_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  code;
    logic [3:0]  an;
    logic [3:0]  nibble;
    logic        frame_tick;
    logic        pending;

    modport master (
        output en, load, digits_in,
        input  code, an, nibble, frame_tick, pending
    );

    modport slave (
        input  en, load, digits_in,
        output code, an, nibble, frame_tick, pending
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - 4-digit time-multiplexed display scanner with double-buffered score
//
// Purpose : rotates a one-hot digit select every DIV clocks and drives the
//           matching active-low anodes and BCD nibble. New scores go into a
//           shadow buffer and are swapped into the active buffer only when the
//           scan wraps from digit3 to digit0, so a frame never tears.
// Params  : DIV - clocks per digit slot (>= 2)
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - digit_scan_ctrl_if.slave
//                  in : en, load, digits_in[15:0]
//                  out: code[3:0], an[3:0], nibble[3:0], frame_tick, pending
// Macros  : SCAN_LZB_EN - when defined, leading-zero blanking of digits 3..1
module digit_scan_ctrl #(
    parameter int DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    digit_scan_ctrl_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_code;
    logic [3:0]    r_an;
    logic [3:0]    r_nibble;
    logic          r_frame_tick;
    logic          r_pending;
    logic [15:0]   r_active;
    logic [15:0]   r_shadow;

    logic          w_tick;
    logic          w_wrap;
    logic          w_swap;
    logic [3:0]    w_code_next;
    logic [15:0]   w_active_next;
    logic [3:0]    w_nibble_next;
    logic [3:0]    w_blank;
    logic [3:0]    w_an_next;

    assign w_tick        = bus.en && (r_cnt == CW'(DIV - 1));
    assign w_wrap        = w_tick && r_code[3];
    assign w_swap        = w_wrap && r_pending;
    assign w_code_next   = w_tick ? {r_code[2:0], r_code[3]} : r_code;
    // The active buffer takes the shadow as it was before this edge, so a load
    // in the swap cycle lands in the shadow for the following frame.
    assign w_active_next = w_swap ? r_shadow : r_active;

    // nibble and anodes are computed from next-state values so that code,
    // an and nibble all change on the same edge.
    always_comb begin
        w_nibble_next = 4'h0;
        unique case (w_code_next)
            4'b0001: w_nibble_next = w_active_next[3:0];
            4'b0010: w_nibble_next = w_active_next[7:4];
            4'b0100: w_nibble_next = w_active_next[11:8];
            4'b1000: w_nibble_next = w_active_next[15:12];
            default: w_nibble_next = 4'h0;
        endcase
    end

`ifdef SCAN_LZB_EN
    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (w_active_next[15:12] == 4'h0);
        w_blank[2] = w_blank[3] && (w_active_next[11:8] == 4'h0);
        w_blank[1] = w_blank[2] && (w_active_next[7:4] == 4'h0);
        w_blank[0] = 1'b0;
    end
`else
    assign w_blank = 4'b0000;
`endif

    assign w_an_next = bus.en ? (~w_code_next | w_blank) : 4'hF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_code       <= 4'b0001;
            r_an         <= 4'hF;
            r_nibble     <= 4'h0;
            r_frame_tick <= 1'b0;
            r_pending    <= 1'b0;
            r_active     <= 16'h0000;
            r_shadow     <= 16'h0000;
        end else begin
            if (bus.en) begin
                r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            end
            r_code       <= w_code_next;
            r_an         <= w_an_next;
            r_nibble     <= w_nibble_next;
            r_frame_tick <= w_wrap;
            r_active     <= w_active_next;
            if (bus.load) begin
                r_shadow  <= bus.digits_in;
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.code       = r_code;
    assign bus.an         = r_an;
    assign bus.nibble     = r_nibble;
    assign bus.frame_tick = r_frame_tick;
    assign bus.pending    = r_pending;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic clk;
    logic rst;

    digit_scan_ctrl_if u_if ();

    digit_scan_ctrl #(.DIV(DIV)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Reference model: position is the number of enabled clocks since reset.
    int          m_e;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic        m_ft;
    logic        m_anen;

    function automatic int m_digit();
        return (m_e / DIV) % 4;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0]  e_code;
        logic [3:0]  e_an;
        logic [3:0]  e_nib;
        logic [15:0] tmp;
        e_code = 4'b0001 << m_digit();
        tmp    = m_active >> (4 * m_digit());
        e_nib  = tmp[3:0];
        e_an   = ~e_code;
`ifdef SCAN_LZB_EN
        for (int i = 1; i < 4; i++) begin
            if ((m_active >> (4 * i)) == 16'h0) e_an[i] = 1'b1;
        end
`endif
        if (!m_anen) e_an = 4'hF;
        chk("code",       {12'h0, u_if.code},       {12'h0, e_code});
        chk("an",         {12'h0, u_if.an},         {12'h0, e_an});
        chk("nibble",     {12'h0, u_if.nibble},     {12'h0, e_nib});
        chk("frame_tick", {15'h0, u_if.frame_tick}, {15'h0, m_ft});
        chk("pending",    {15'h0, u_if.pending},    {15'h0, m_pending});
    endtask

    task automatic step();
        logic        s_rst;
        logic        s_en;
        logic        s_load;
        logic [15:0] s_din;
        s_rst  = rst;
        s_en   = u_if.en;
        s_load = u_if.load;
        s_din  = u_if.digits_in;
        @(posedge clk);
        if (s_rst) begin
            m_e = 0; m_active = 16'h0; m_shadow = 16'h0;
            m_pending = 1'b0; m_ft = 1'b0; m_anen = 1'b0;
        end else begin
            m_ft = 1'b0;
            if (s_en) begin
                m_e++;
                if (m_e % FRAME == 0) begin
                    m_ft = 1'b1;
                    if (m_pending) begin
                        m_active  = m_shadow;
                        m_pending = 1'b0;
                    end
                end
            end
            if (s_load) begin
                m_shadow  = s_din;
                m_pending = 1'b1;
            end
            m_anen = s_en;
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic load_val(input logic [15:0] v);
        u_if.load = 1'b1; u_if.digits_in = v;
        step();
        u_if.load = 1'b0;
    endtask

    initial begin
        int k;
        n_assert = 0; n_fail = 0;
        m_e = 0; m_active = 0; m_shadow = 0; m_pending = 0; m_ft = 0; m_anen = 0;
        rst = 1'b1; u_if.en = 1'b0; u_if.load = 1'b0; u_if.digits_in = 16'h0;
        #2;
        run(2);
        chk("rst_code", {12'h0, u_if.code}, 16'h0001);
        chk("rst_an",   {12'h0, u_if.an},   16'h000F);
        rst = 1'b0;

        // Free-running scan, several frames.
        u_if.en = 1'b1;
        step();
        chk("first_an", {12'h0, u_if.an}, 16'h000E);
        run(40);

        // Mid-frame load, then watch it arrive at the wrap.
        run(5);
        load_val(16'h1234);
        chk("pend_1234", {15'h0, u_if.pending}, 16'h0001);
        run(2 * FRAME);

        // Load 0x1111, then 0x5678 exactly in the swap cycle.
        load_val(16'h1111);
        for (k = 0; k < 2 * FRAME && ((m_e + 1) % FRAME) != 0; k++) step();
        chk("wait_wrap", {15'h0, (((m_e + 1) % FRAME) == 0)}, 16'h0001);
        load_val(16'h5678);
        chk("swap_pend", {15'h0, u_if.pending}, 16'h0001);
        chk("swap_nib",  {12'h0, u_if.nibble},  16'h0001);
        run(2 * FRAME + 3);

        // Freeze while digit2 is selected.
        for (k = 0; k < 2 * FRAME && m_digit() != 2; k++) step();
        chk("wait_d2", {14'h0, 2'(m_digit())}, 16'h0002);
        run(1);
        u_if.en = 1'b0;
        run(10);
        chk("frz_an", {12'h0, u_if.an}, 16'h000F);
        u_if.en = 1'b1;
        run(FRAME);

        // Leading-zero pattern, visible in both builds.
        load_val(16'h0070);
        run(2 * FRAME);
        load_val(16'h0000);
        run(2 * FRAME);

        // Reset with data pending while digit3 is selected.
        for (k = 0; k < 2 * FRAME && m_digit() != 3; k++) step();
        load_val(16'h9876);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_pend", {15'h0, u_if.pending}, 16'h0000);
        chk("rst2_code", {12'h0, u_if.code},    16'h0001);
        run(2 * FRAME);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            u_if.en        = ($urandom_range(0, 9) != 0);
            u_if.load      = ($urandom_range(0, 19) == 0);
            u_if.digits_in = 16'($urandom);
            if ($urandom_range(0, 5) == 0) u_if.digits_in[15:8] = 8'h00;
            rst            = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; u_if.load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Drives the time-multiplexed 4-digit scoreboard display by producing the rotating one-hot `code[3:0]` select that the one-hot AND-OR digit multiplexers consume. It also drives the matching active-low anode lines and the selected BCD nibble. Score values are double-buffered: a new value is accepted at any time but only reaches the display at a frame boundary, so a digit never shows a mix of old and new values. It sits between the score logic and the 7-segment decoder/anode pins.

## Interface
- `DIV`, 50000, prescaler period in clocks per digit slot; ≥2 (50 MHz → 1 kHz/digit, 250 Hz frame).
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  scan enable; low freezes the scan and blanks all anodes.
- `load`  input  1  one-cycle strobe; captures `digits_in` into the shadow buffer.
- `digits_in`  input  16  four BCD nibbles; [3:0] is digit0 (rightmost) … [15:12] is digit3.
- `code`  output  4  one-hot digit select to the mux arrays; bit i selects digit i.
- `an`  output  4  active-low anodes; bit i drives digit i.
- `nibble`  output  4  active-buffer nibble for the digit selected by `code`.
- `frame_tick`  output  1  one-cycle pulse when the scan wraps from digit3 to digit0.
- `pending`  output  1  shadow buffer holds data not yet swapped into the active buffer.

## Operation
- Prescaler `cnt` counts 0 to DIV-1 while `en`=1. `tick` asserts when `cnt`=DIV-1 and `en`=1. `cnt` returns to 0 on the following edge.
- Ring register: on `tick`, `code` rotates left: 0001→0010→0100→1000→0001. It holds otherwise. It is never zero and never multi-hot.
- Frame boundary is a `tick` with `code`=1000.
  - On that edge, if `pending`=1: active←shadow and `pending`←0.
  - On that edge, `frame_tick`←1 for exactly one cycle.
- `load`=1: shadow←`digits_in`, `pending`←1. Loads take effect regardless of `en`. Back-to-back loads overwrite the shadow; the last one wins.
- `load` on the same cycle as a swap:
  - The active buffer takes the old shadow value.
  - The shadow takes the new `digits_in`.
  - `pending` stays 1.
- `nibble` = active[4i+3:4i] for the one-hot index i of the next `code`. It is registered together with `code`.
- `an` = ~`code` when `en`=1 (subject to blanking, see Configuration). `an` = 1111 when `en`=0.
- `en` falling:
  - `cnt` and `code` hold their values.
  - `an` goes to 1111 on the next edge.
  - When `en` rises again, scanning resumes from the held `code`/`cnt`.
- Nibbles are passed through unchecked. Values above 9 are the decoder's concern.

## Timing
- Reset values: `code`=0001, `an`=1111, `nibble`=0, `frame_tick`=0, `pending`=0. Internally, `cnt`=0, active=0, and shadow=0.
- `rst` overrides `load` and `en` in the same cycle. A mid-frame reset discards any pending data.
- All outputs are registered. `code`, `an`, and `nibble` change together on the edge after `tick`.
- First anode enable: the first edge with `en`=1 after reset sets `an`=1110.
- Digit slot length: exactly DIV clocks. Frame length: 4·DIV clocks.
- `frame_tick` asserts on the same edge that `code` becomes 0001. `nibble` shows the newly swapped value on that same edge.
- `load`→display latency is at most 4·DIV+1 clocks, with no tearing within a frame.

## Configuration
- `SCAN_LZB_EN` defined: leading-zero blanking.
  - A digit i≥1 has its `an` bit forced to 1 when its nibble and every nibble above it in the active buffer are 0.
  - Digit0 is never blanked.
  - `code` and `nibble` are unaffected.
- `SCAN_LZB_EN` undefined: `an` = ~`code` whenever `en`=1, and all digits are shown.

## Test plan
- Reset, `en`=1, DIV=4: `code` follows 0001,0010,0100,1000,0001, each held 4 clocks. `frame_tick` pulses once per 16 clocks, on the 0001 edge.
- Load 0x1234 mid-frame: `pending`=1. The display shows 0000 until the wrap. Then `nibble` steps 4,3,2,1 and `pending`=0.
- Load 0x1111, then 0x5678 in the swap cycle: the next frame shows 1111, the following frame shows 5678, and `pending` stays 1 between them.
- Drop `en` while `code`=0100 for 10 cycles: `an`=1111, and `code`/`cnt` hold. After `en` rises, 0100 completes its remaining slot.
- Assert `rst` with `pending`=1 and `code`=1000: all outputs return to reset values, and the next frame shows 0000.
- With `SCAN_LZB_EN` and active 0x0070: `an` is 1 for digit3 and digit2; digit1 (7) and digit0 (0) are lit. With active 0x0000, only digit0 is lit.
